// File: rtl/ps2_key_event.sv
`default_nettype none
// ============================================================================
// Module      : ps2_key_event
// Description : PS/2 keyboard front-end: frame receiver, scan-code set 2
//               prefix decoder, held-key tracking and an event FIFO with a
//               valid/ready output. Optional parity check is enabled by
//               defining PS2_KEY_EVENT_PARITY_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_key_event #(
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 8,
    parameter int TIMEOUT    = 50000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ps2_clk,
    input  logic             ps2_data,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [7:0]       evt_code,
    output logic             evt_ext,
    output logic             evt_break,
    output logic             key_held,
    output logic [8:0]       held_code,
    output logic [CNT_W-1:0] press_cnt,
    output logic             overflow,
    output logic             frame_err
);

    localparam int c_ptr_w = $clog2(FIFO_DEPTH);
    localparam int c_wd_w  = $clog2(TIMEOUT + 1);
    localparam logic [c_wd_w-1:0] c_wd_last = c_wd_w'(TIMEOUT - 1);

    typedef enum logic [0:0] {
        RX_IDLE  = 1'b0,
        RX_SHIFT = 1'b1
    } rx_state_t;

    typedef enum logic [2:0] {
        DEC_BASE    = 3'd0,
        DEC_EXT     = 3'd1,
        DEC_BRK     = 3'd2,
        DEC_EXT_BRK = 3'd3,
        DEC_PAUSE   = 3'd4
    } dec_state_t;

    logic [2:0]        r_clk_sync;
    logic [1:0]        r_dat_sync;
    logic              w_fall;
    logic              w_bit;

    rx_state_t         r_rx_state, w_rx_next;
    logic [3:0]        r_bit_cnt;
    logic [7:0]        r_shift;
    logic [c_wd_w-1:0] r_wd;
    logic              w_wd_expire;
    logic              w_stop;
    logic              w_frame_ok;
    logic              r_byte_done;
    logic [7:0]        r_byte;
    logic              r_frame_err;
`ifdef PS2_KEY_EVENT_PARITY_CHECK_EN
    logic              r_par;
`endif

    dec_state_t        r_dec_state, w_dec_next;
    logic [2:0]        r_skip, w_skip_next;
    logic              w_evt_push;
    logic              w_evt_ext;
    logic              w_evt_brk;
    logic              w_make_new;

    logic              r_key_held;
    logic [8:0]        r_held_code;
    logic [CNT_W-1:0]  r_press_cnt;
    logic              r_overflow;

    logic [9:0]        r_mem [FIFO_DEPTH];
    logic [c_ptr_w:0]  r_wr_ptr, r_rd_ptr;
    logic              w_empty, w_full, w_pop, w_push_ok;
    logic [9:0]        w_head;

    // Sync chains idle high so reset never fabricates a falling edge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_clk_sync <= 3'b111;
            r_dat_sync <= 2'b11;
        end else begin
            r_clk_sync <= {r_clk_sync[1:0], ps2_clk};
            r_dat_sync <= {r_dat_sync[0], ps2_data};
        end
    end

    assign w_fall = r_clk_sync[2] & ~r_clk_sync[1];
    assign w_bit  = r_dat_sync[1];

`ifdef PS2_KEY_EVENT_PARITY_CHECK_EN
    assign w_frame_ok = w_bit & (^{r_shift, r_par});
`else
    assign w_frame_ok = w_bit;
`endif

    always_comb begin
        w_rx_next   = r_rx_state;
        w_wd_expire = 1'b0;
        w_stop      = 1'b0;
        case (r_rx_state)
            RX_IDLE: begin
                if (w_fall && !w_bit) w_rx_next = RX_SHIFT;
            end
            RX_SHIFT: begin
                // Watchdog wins over a coincident edge
                if (r_wd == c_wd_last) begin
                    w_wd_expire = 1'b1;
                    w_rx_next   = RX_IDLE;
                end else if (w_fall && (r_bit_cnt == 4'd9)) begin
                    w_stop    = 1'b1;
                    w_rx_next = RX_IDLE;
                end
            end
            default: w_rx_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_state  <= RX_IDLE;
            r_bit_cnt   <= 4'd0;
            r_shift     <= 8'd0;
            r_wd        <= '0;
            r_byte_done <= 1'b0;
            r_byte      <= 8'd0;
            r_frame_err <= 1'b0;
`ifdef PS2_KEY_EVENT_PARITY_CHECK_EN
            r_par       <= 1'b0;
`endif
        end else begin
            r_rx_state  <= w_rx_next;
            r_byte_done <= w_stop && w_frame_ok;
            if (w_stop && w_frame_ok) r_byte <= r_shift;
            if ((w_stop && !w_frame_ok) || w_wd_expire) r_frame_err <= 1'b1;
            if ((r_rx_state == RX_IDLE) || w_fall) r_wd <= '0;
            else                                   r_wd <= r_wd + c_wd_w'(1);
            if (r_rx_state == RX_IDLE) begin
                r_bit_cnt <= 4'd0;
            end else if (w_fall) begin
                if (r_bit_cnt < 4'd8) r_shift <= {w_bit, r_shift[7:1]};
`ifdef PS2_KEY_EVENT_PARITY_CHECK_EN
                else if (r_bit_cnt == 4'd8) r_par <= w_bit;
`endif
                r_bit_cnt <= r_bit_cnt + 4'd1;
            end
        end
    end

    always_comb begin
        w_dec_next  = r_dec_state;
        w_skip_next = r_skip;
        w_evt_push  = 1'b0;
        w_evt_ext   = 1'b0;
        w_evt_brk   = 1'b0;
        if (r_byte_done) begin
            case (r_dec_state)
                DEC_BASE: begin
                    if (r_byte == 8'hE0) begin
                        w_dec_next = DEC_EXT;
                    end else if (r_byte == 8'hF0) begin
                        w_dec_next = DEC_BRK;
                    end else if (r_byte == 8'hE1) begin
                        w_dec_next  = DEC_PAUSE;
                        w_skip_next = 3'd7;
                    end else begin
                        w_evt_push = 1'b1;
                    end
                end
                DEC_EXT: begin
                    if (r_byte == 8'hF0) begin
                        w_dec_next = DEC_EXT_BRK;
                    end else begin
                        w_evt_push = 1'b1;
                        w_evt_ext  = 1'b1;
                        w_dec_next = DEC_BASE;
                    end
                end
                DEC_BRK: begin
                    w_evt_push = 1'b1;
                    w_evt_brk  = 1'b1;
                    w_dec_next = DEC_BASE;
                end
                DEC_EXT_BRK: begin
                    w_evt_push = 1'b1;
                    w_evt_ext  = 1'b1;
                    w_evt_brk  = 1'b1;
                    w_dec_next = DEC_BASE;
                end
                DEC_PAUSE: begin
                    w_skip_next = r_skip - 3'd1;
                    if (r_skip == 3'd1) w_dec_next = DEC_BASE;
                end
                default: w_dec_next = DEC_BASE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dec_state <= DEC_BASE;
            r_skip      <= 3'd0;
        end else begin
            r_dec_state <= w_dec_next;
            r_skip      <= w_skip_next;
        end
    end

    // A repeat of the held key is typematic and does not count as a press
    assign w_make_new = w_evt_push && !w_evt_brk &&
                        (!r_key_held || (r_held_code != {w_evt_ext, r_byte}));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_key_held  <= 1'b0;
            r_held_code <= 9'd0;
            r_press_cnt <= '0;
        end else if (w_make_new) begin
            r_key_held  <= 1'b1;
            r_held_code <= {w_evt_ext, r_byte};
            r_press_cnt <= r_press_cnt + CNT_W'(1);
        end else if (w_evt_push && w_evt_brk && (r_held_code == {w_evt_ext, r_byte})) begin
            r_key_held  <= 1'b0;
        end
    end

    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[c_ptr_w] != r_rd_ptr[c_ptr_w]) &&
                       (r_wr_ptr[c_ptr_w-1:0] == r_rd_ptr[c_ptr_w-1:0]);
    assign w_pop     = !w_empty && evt_ready;
    assign w_push_ok = w_evt_push && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr[c_ptr_w-1:0]] <= {w_evt_ext, w_evt_brk, r_byte};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + (c_ptr_w + 1)'(1);
            if (w_pop)     r_rd_ptr <= r_rd_ptr + (c_ptr_w + 1)'(1);
            if (w_evt_push && w_full && !w_pop) r_overflow <= 1'b1;
        end
    end

    assign w_head    = r_mem[r_rd_ptr[c_ptr_w-1:0]];
    assign evt_valid = !w_empty;
    assign evt_code  = w_empty ? 8'd0 : w_head[7:0];
    assign evt_break = w_empty ? 1'b0 : w_head[8];
    assign evt_ext   = w_empty ? 1'b0 : w_head[9];
    assign key_held  = r_key_held;
    assign held_code = r_held_code;
    assign press_cnt = r_press_cnt;
    assign overflow  = r_overflow;
    assign frame_err = r_frame_err;

endmodule
`default_nettype wire
